// File: rtl/dispatch_buffer_param.sv
// One-entry dispatch buffer: resolves operands at capture, snoops CDB while held, issues next cycle.
// Decode stalls while the held entry cannot issue (station full, ROB full) or on flush.
module dispatch_buffer_param #(
   parameter int ROB_SIZE = 8,
   parameter int TAG_W    = $clog2(ROB_SIZE + 1),
   parameter int NUM_RS   = 4,
   parameter int RS_SEL_W = $clog2(NUM_RS),
   parameter int NUM_CDB  = 2,
   parameter int DATA_W   = 64,
   parameter int CMD_W    = 10
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      dec_valid_i,
   output logic                      dec_ready_o,
   input  logic [TAG_W-1:0]          dec_tag1_i,
   input  logic [TAG_W-1:0]          dec_tag2_i,
   input  logic                      dec_use_imm_i,
   input  logic [DATA_W-1:0]         dec_imm_i,
   input  logic [DATA_W-1:0]         reg_data1_i,
   input  logic [DATA_W-1:0]         reg_data2_i,
   input  logic [DATA_W:0]           rob_data1_i,
   input  logic [DATA_W:0]           rob_data2_i,
   input  logic [RS_SEL_W-1:0]       dec_rs_sel_i,
   input  logic [CMD_W-1:0]          dec_cmd_i,
   input  logic [TAG_W-1:0]          rob_tail_i,
   input  logic                      rob_full_i,
   output logic                      rob_alloc_o,
   input  logic [NUM_CDB-1:0]        cdb_valid_i,
   input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag_i,
   input  logic [NUM_CDB*DATA_W-1:0] cdb_data_i,
   input  logic                      flush_i,
   input  logic [NUM_RS-1:0]         rs_stall_i,
   output logic [NUM_RS-1:0]         rs_write_en_o,
   output logic [TAG_W-1:0]          rs_dest_tag_o,
   output logic [TAG_W-1:0]          rs_tag1_o,
   output logic [TAG_W-1:0]          rs_tag2_o,
   output logic [DATA_W-1:0]         rs_val1_o,
   output logic [DATA_W-1:0]         rs_val2_o,
   output logic [CMD_W-1:0]          rs_cmd_o
);

   typedef enum logic {EMPTY, FULL} state_t;

   typedef struct packed {
      logic [TAG_W-1:0]    tag1;
      logic [TAG_W-1:0]    tag2;
      logic [DATA_W-1:0]   val1;
      logic [DATA_W-1:0]   val2;
      logic [CMD_W-1:0]    cmd;
      logic [RS_SEL_W-1:0] sel;
   } entry_t;

   state_t state_q, state_d;
   entry_t held_q, held_d, cap;
   logic   fire, accept, sel_ok;
   logic [DATA_W:0] snoop1, snoop2, cap_cdb1, cap_cdb2;

   // Returns {hit, data}; the downward scan lets the lowest port win. Tag 0 never matches.
   function automatic logic [DATA_W:0] cdb_hit(input logic [TAG_W-1:0] tag);
      logic [DATA_W:0] r;
      r = '0;
      for (int p = NUM_CDB - 1; p >= 0; p--) begin
         if (tag != '0 && cdb_valid_i[p] && cdb_tag_i[p*TAG_W +: TAG_W] == tag)
            r = {1'b1, cdb_data_i[p*DATA_W +: DATA_W]};
      end
      return r;
   endfunction

   always_comb begin
      snoop1 = cdb_hit(held_q.tag1);
      snoop2 = cdb_hit(held_q.tag2);
      sel_ok = int'(held_q.sel) < NUM_RS;
      fire   = reset_i && state_q == FULL && sel_ok && !rs_stall_i[held_q.sel]
               && !rob_full_i && !flush_i;
      dec_ready_o = reset_i && !flush_i && (state_q == EMPTY || fire);
      accept = dec_valid_i && dec_ready_o;

      cap      = '0;
      cap.cmd  = dec_cmd_i;
      cap.sel  = dec_rs_sel_i;
      cap_cdb1 = cdb_hit(dec_tag1_i);
      cap_cdb2 = cdb_hit(dec_tag2_i);
      if (dec_tag1_i == '0)          cap.val1 = reg_data1_i;
      else if (cap_cdb1[DATA_W])     cap.val1 = cap_cdb1[DATA_W-1:0];
      else if (rob_data1_i[DATA_W])  cap.val1 = rob_data1_i[DATA_W-1:0];
      else                           cap.tag1 = dec_tag1_i;
      if (dec_use_imm_i)             cap.val2 = dec_imm_i;
      else if (dec_tag2_i == '0)     cap.val2 = reg_data2_i;
      else if (cap_cdb2[DATA_W])     cap.val2 = cap_cdb2[DATA_W-1:0];
      else if (rob_data2_i[DATA_W])  cap.val2 = rob_data2_i[DATA_W-1:0];
      else                           cap.tag2 = dec_tag2_i;

      held_d = held_q;
      if (snoop1[DATA_W]) begin
         held_d.tag1 = '0;
         held_d.val1 = snoop1[DATA_W-1:0];
      end
      if (snoop2[DATA_W]) begin
         held_d.tag2 = '0;
         held_d.val2 = snoop2[DATA_W-1:0];
      end
      if (accept) held_d = cap;

      state_d = state_q;
      if (flush_i)     state_d = EMPTY;
      else if (accept) state_d = FULL;
      else if (fire)   state_d = EMPTY;

      // Issue view merges a same-cycle wakeup so the station never sees a stale tag.
      rs_tag1_o = snoop1[DATA_W] ? '0 : held_q.tag1;
      rs_tag2_o = snoop2[DATA_W] ? '0 : held_q.tag2;
      rs_val1_o = snoop1[DATA_W] ? snoop1[DATA_W-1:0] : held_q.val1;
      rs_val2_o = snoop2[DATA_W] ? snoop2[DATA_W-1:0] : held_q.val2;
      rs_cmd_o  = held_q.cmd;
      for (int i = 0; i < NUM_RS; i++)
         rs_write_en_o[i] = fire && (int'(held_q.sel) == i);
      rob_alloc_o   = fire;
      rs_dest_tag_o = fire ? rob_tail_i : '0;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= EMPTY;
         held_q  <= '0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
      end
   end

endmodule

// File: tb/tb_dispatch_buffer_param.sv
// Directed bench for dispatch_buffer_param: inputs driven just after falling edges, outputs checked 1ns later.
module tb_dispatch_buffer_param;

   logic         clk_i = 1'b0;
   logic         reset_i;
   logic         dec_valid_i, dec_ready_o;
   logic [3:0]   dec_tag1_i, dec_tag2_i;
   logic         dec_use_imm_i;
   logic [63:0]  dec_imm_i, reg_data1_i, reg_data2_i;
   logic [64:0]  rob_data1_i, rob_data2_i;
   logic [1:0]   dec_rs_sel_i;
   logic [9:0]   dec_cmd_i;
   logic [3:0]   rob_tail_i;
   logic         rob_full_i, rob_alloc_o;
   logic [1:0]   cdb_valid_i;
   logic [7:0]   cdb_tag_i;
   logic [127:0] cdb_data_i;
   logic         flush_i;
   logic [3:0]   rs_stall_i, rs_write_en_o;
   logic [3:0]   rs_dest_tag_o, rs_tag1_o, rs_tag2_o;
   logic [63:0]  rs_val1_o, rs_val2_o;
   logic [9:0]   rs_cmd_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   dispatch_buffer_param dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
      .dec_tag1_i(dec_tag1_i), .dec_tag2_i(dec_tag2_i),
      .dec_use_imm_i(dec_use_imm_i), .dec_imm_i(dec_imm_i),
      .reg_data1_i(reg_data1_i), .reg_data2_i(reg_data2_i),
      .rob_data1_i(rob_data1_i), .rob_data2_i(rob_data2_i),
      .dec_rs_sel_i(dec_rs_sel_i), .dec_cmd_i(dec_cmd_i),
      .rob_tail_i(rob_tail_i), .rob_full_i(rob_full_i), .rob_alloc_o(rob_alloc_o),
      .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
      .flush_i(flush_i), .rs_stall_i(rs_stall_i), .rs_write_en_o(rs_write_en_o),
      .rs_dest_tag_o(rs_dest_tag_o), .rs_tag1_o(rs_tag1_o), .rs_tag2_o(rs_tag2_o),
      .rs_val1_o(rs_val1_o), .rs_val2_o(rs_val2_o), .rs_cmd_o(rs_cmd_o)
   );

   task automatic step();
      @(negedge clk_i);
   endtask

   task automatic idle();
      dec_valid_i = 0; dec_tag1_i = 0; dec_tag2_i = 0; dec_use_imm_i = 0;
      dec_imm_i = 0; reg_data1_i = 0; reg_data2_i = 0;
      rob_data1_i = 0; rob_data2_i = 0; dec_rs_sel_i = 0; dec_cmd_i = 0;
      rob_tail_i = 0; rob_full_i = 0; cdb_valid_i = 0; cdb_tag_i = 0;
      cdb_data_i = 0; flush_i = 0; rs_stall_i = 0;
   endtask

   task automatic test_reset();
      reset_i = 0; idle();
      step(); step();
      reset_i = 1; #1;
      n_checks++; if (dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", dec_ready_o); end
      n_checks++; if (rs_write_en_o !== 4'b0000) begin n_fail++; $display("FAIL reset_wen got %b exp 0000", rs_write_en_o); end
      n_checks++; if (rob_alloc_o !== 1'b0) begin n_fail++; $display("FAIL reset_alloc got %b exp 0", rob_alloc_o); end
      n_checks++; if (rs_val1_o !== 64'h0) begin n_fail++; $display("FAIL reset_val1 got %h exp 0", rs_val1_o); end
   endtask

   task automatic test_imm_issue();
      step();
      dec_valid_i = 1; reg_data1_i = 64'h55; dec_use_imm_i = 1; dec_imm_i = 64'h10;
      dec_rs_sel_i = 2; dec_cmd_i = 10'h2A5; #1;
      n_checks++; if (dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL imm_accept got %b exp 1", dec_ready_o); end
      step(); idle(); rob_tail_i = 4; #1;
      n_checks++; if (rs_write_en_o !== 4'b0100) begin n_fail++; $display("FAIL imm_wen got %b exp 0100", rs_write_en_o); end
      n_checks++; if (rs_val1_o !== 64'h55) begin n_fail++; $display("FAIL imm_val1 got %h exp 55", rs_val1_o); end
      n_checks++; if (rs_val2_o !== 64'h10) begin n_fail++; $display("FAIL imm_val2 got %h exp 10", rs_val2_o); end
      n_checks++; if ({rs_tag1_o, rs_tag2_o} !== 8'h00) begin n_fail++; $display("FAIL imm_tags got %h exp 00", {rs_tag1_o, rs_tag2_o}); end
      n_checks++; if (rob_alloc_o !== 1'b1) begin n_fail++; $display("FAIL imm_alloc got %b exp 1", rob_alloc_o); end
      n_checks++; if (rs_dest_tag_o !== 4'd4) begin n_fail++; $display("FAIL imm_dest got %h exp 4", rs_dest_tag_o); end
      n_checks++; if (rs_cmd_o !== 10'h2A5) begin n_fail++; $display("FAIL imm_cmd got %h exp 2a5", rs_cmd_o); end
      step(); #1;
      n_checks++; if (rs_write_en_o !== 4'b0000) begin n_fail++; $display("FAIL imm_empty_wen got %b exp 0000", rs_write_en_o); end
      n_checks++; if (dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL imm_empty_ready got %b exp 1", dec_ready_o); end
   endtask

   task automatic test_cdb_wakeup();
      step(); idle();
      dec_valid_i = 1; dec_tag1_i = 3; rob_data1_i = {1'b0, 64'h77};
      dec_use_imm_i = 1; dec_imm_i = 64'h20; dec_rs_sel_i = 1; rs_stall_i = 4'b0010;
      step(); idle(); rs_stall_i = 4'b0010;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_checks++; if (rs_tag1_o !== 4'd3) begin n_fail++; $display("FAIL wake_pending_tag got %h exp 3", rs_tag1_o); end
         n_checks++; if (rs_write_en_o !== 4'b0000) begin n_fail++; $display("FAIL wake_stall_wen got %b exp 0000", rs_write_en_o); end
         n_checks++; if (dec_ready_o !== 1'b0) begin n_fail++; $display("FAIL wake_stall_ready got %b exp 0", dec_ready_o); end
         step();
      end
      cdb_valid_i = 2'b10; cdb_tag_i = {4'd3, 4'd0}; cdb_data_i = {64'hAB, 64'h0}; #1;
      n_checks++; if (rs_tag1_o !== 4'd0) begin n_fail++; $display("FAIL wake_merge_tag got %h exp 0", rs_tag1_o); end
      n_checks++; if (rs_val1_o !== 64'hAB) begin n_fail++; $display("FAIL wake_merge_val got %h exp ab", rs_val1_o); end
      step(); cdb_valid_i = 0; cdb_tag_i = 0; cdb_data_i = 0; #1;
      n_checks++; if (rs_tag1_o !== 4'd0 || rs_val1_o !== 64'hAB) begin n_fail++; $display("FAIL wake_held got tag %h val %h exp 0 ab", rs_tag1_o, rs_val1_o); end
      n_checks++; if (rs_write_en_o !== 4'b0000) begin n_fail++; $display("FAIL wake_held_wen got %b exp 0000", rs_write_en_o); end
      step(); rs_stall_i = 0; #1;
      n_checks++; if (rs_write_en_o !== 4'b0010) begin n_fail++; $display("FAIL wake_issue_wen got %b exp 0010", rs_write_en_o); end
      n_checks++; if (rs_tag1_o !== 4'd0 || rs_val1_o !== 64'hAB || rs_val2_o !== 64'h20) begin n_fail++; $display("FAIL wake_issue_ops got %h %h %h exp 0 ab 20", rs_tag1_o, rs_val1_o, rs_val2_o); end
   endtask

   task automatic test_cdb_priority();
      step(); idle();
      dec_valid_i = 1; dec_tag1_i = 5; rob_data1_i = {1'b1, 64'hEE}; reg_data2_i = 64'h33;
      cdb_valid_i = 2'b11; cdb_tag_i = {4'd5, 4'd5}; cdb_data_i = {64'h2, 64'h1};
      step(); idle(); #1;
      n_checks++; if (rs_write_en_o !== 4'b0001) begin n_fail++; $display("FAIL prio_wen got %b exp 0001", rs_write_en_o); end
      n_checks++; if (rs_val1_o !== 64'h1 || rs_tag1_o !== 4'd0) begin n_fail++; $display("FAIL prio_val1 got %h tag %h exp 1 0", rs_val1_o, rs_tag1_o); end
      n_checks++; if (rs_val2_o !== 64'h33) begin n_fail++; $display("FAIL prio_reg2 got %h exp 33", rs_val2_o); end
      // ROB-ready capture on op1, pending op2 woken in the issue cycle itself.
      dec_valid_i = 1; dec_tag1_i = 6; rob_data1_i = {1'b1, 64'h44};
      dec_tag2_i = 7; rob_data2_i = {1'b0, 64'h1}; dec_rs_sel_i = 1;
      step(); idle();
      cdb_valid_i = 2'b01; cdb_tag_i = {4'd0, 4'd7}; cdb_data_i = {64'h0, 64'h66}; #1;
      n_checks++; if (rs_write_en_o !== 4'b0010) begin n_fail++; $display("FAIL rob_wen got %b exp 0010", rs_write_en_o); end
      n_checks++; if (rs_val1_o !== 64'h44) begin n_fail++; $display("FAIL rob_val1 got %h exp 44", rs_val1_o); end
      n_checks++; if (rs_tag2_o !== 4'd0 || rs_val2_o !== 64'h66) begin n_fail++; $display("FAIL late_wake got tag %h val %h exp 0 66", rs_tag2_o, rs_val2_o); end
   endtask

   task automatic test_back_to_back();
      step(); idle();
      dec_valid_i = 1; reg_data1_i = 64'h11; dec_use_imm_i = 1; dec_imm_i = 64'h12; dec_rs_sel_i = 3;
      step();
      reg_data1_i = 64'h21; dec_rs_sel_i = 0; rob_full_i = 1;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_checks++; if (rs_write_en_o !== 4'b0000 || rob_alloc_o !== 1'b0) begin n_fail++; $display("FAIL robfull_strobe got %b %b exp 0000 0", rs_write_en_o, rob_alloc_o); end
         n_checks++; if (dec_ready_o !== 1'b0) begin n_fail++; $display("FAIL robfull_ready got %b exp 0", dec_ready_o); end
         step();
      end
      rob_full_i = 0; #1;
      n_checks++; if (rs_write_en_o !== 4'b1000 || rob_alloc_o !== 1'b1) begin n_fail++; $display("FAIL b2b_fire got %b %b exp 1000 1", rs_write_en_o, rob_alloc_o); end
      n_checks++; if (dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b exp 1", dec_ready_o); end
      n_checks++; if (rs_val1_o !== 64'h11) begin n_fail++; $display("FAIL b2b_first_val got %h exp 11", rs_val1_o); end
      step(); idle(); #1;
      n_checks++; if (rs_write_en_o !== 4'b0001 || rs_val1_o !== 64'h21) begin n_fail++; $display("FAIL b2b_second got %b %h exp 0001 21", rs_write_en_o, rs_val1_o); end
   endtask

   task automatic test_flush();
      step(); idle();
      dec_valid_i = 1; reg_data1_i = 64'h5;
      step(); flush_i = 1; #1;
      n_checks++; if (rs_write_en_o !== 4'b0000 || rob_alloc_o !== 1'b0) begin n_fail++; $display("FAIL flush_strobe got %b %b exp 0000 0", rs_write_en_o, rob_alloc_o); end
      n_checks++; if (dec_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b exp 0", dec_ready_o); end
      step(); idle(); #1;
      n_checks++; if (rs_write_en_o !== 4'b0000) begin n_fail++; $display("FAIL flush_empty_wen got %b exp 0000", rs_write_en_o); end
      n_checks++; if (dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_empty_ready got %b exp 1", dec_ready_o); end
   endtask

   task automatic test_reset_mid_hold();
      step(); idle();
      dec_valid_i = 1; dec_tag1_i = 2; rob_data1_i = {1'b0, 64'h9}; reg_data2_i = 64'h8;
      step(); idle(); reset_i = 0; #1;
      n_checks++; if (rs_write_en_o !== 4'b0000 || rob_alloc_o !== 1'b0) begin n_fail++; $display("FAIL rst_hold_strobe got %b %b exp 0000 0", rs_write_en_o, rob_alloc_o); end
      step(); reset_i = 1; #1;
      n_checks++; if (rs_tag1_o !== 4'd0 || rs_val2_o !== 64'h0) begin n_fail++; $display("FAIL rst_hold_clear got %h %h exp 0 0", rs_tag1_o, rs_val2_o); end
      n_checks++; if (rs_write_en_o !== 4'b0000 || dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_hold_empty got %b %b exp 0000 1", rs_write_en_o, dec_ready_o); end
   endtask

   initial begin
      test_reset();
      test_imm_issue();
      test_cdb_wakeup();
      test_cdb_priority();
      test_back_to_back();
      test_flush();
      test_reset_mid_hold();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
